trap_sequencer: RTL

// Parametrised pre-trap-handling (PTH) sequencer for the RV32 core. It accepts exceptions, prioritised

---
 rtl/trap_sequencer_pkg.sv | 32 +++
 rtl/trap_sequencer_if.sv | 30 +++
 rtl/irq_priority_encoder.sv | 15 +
 rtl/trap_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: state, trap kind, CSR address and mstatus constants for the trap sequencer
package trap_sequencer_pkg;
  typedef enum logic [2:0] {
    K_EXC    = 3'd0,
    K_ECALL  = 3'd1,
    K_EBREAK = 3'd2,
    K_MRET   = 3'd3,
    K_FENCEI = 3'd4
  } trap_kind_e;
  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_DRAIN       = 4'd1;
  localparam logic [3:0] S_W_MEPC      = 4'd2;
  localparam logic [3:0] S_W_MCAUSE    = 4'd3;
  localparam logic [3:0] S_W_MTVAL     = 4'd4;
  localparam logic [3:0] S_R_MSTATUS   = 4'd5;
  localparam logic [3:0] S_W_MSTATUS   = 4'd6;
  localparam logic [3:0] S_R_MTVEC     = 4'd7;
  localparam logic [3:0] S_REDIRECT    = 4'd8;
  localparam logic [3:0] S_R_MEPC      = 4'd9;
  localparam logic [3:0] S_R_MSTATUS_M = 4'd10;
  localparam logic [3:0] S_W_MSTATUS_M = 4'd11;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: trap request, interrupt, CSR port and redirect signals of the trap sequencer
interface trap_sequencer_if #(parameter int XLEN = 32, parameter int NUM_IRQ = 4);
  import trap_sequencer_pkg::*;
  logic               trap_valid;
  trap_kind_e         trap_kind;
  logic [4:0]         trap_code;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    trap_tval;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_enable;
  logic [XLEN-1:0]    irq_pc;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_we;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               busy;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush;
  logic               ic_clean;
  logic               debug_mode;
  modport master (
    input  trap_valid, trap_kind, trap_code, trap_pc, trap_tval, irq_pending, irq_enable, irq_pc, csr_rdata,
    output csr_we, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, flush, ic_clean, debug_mode
  );
  modport slave (
    output trap_valid, trap_kind, trap_code, trap_pc, trap_tval, irq_pending, irq_enable, irq_pc, csr_rdata,
    input  csr_we, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, flush, ic_clean, debug_mode
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: lowest-index-wins encoder over the enabled interrupt lines
module irq_priority_encoder #(
  parameter int NUM_IRQ = 4,
  parameter int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IW-1:0]      idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry/MRET CSR sequencer with PC redirect and flush
module trap_sequencer #(
  parameter int XLEN          = 32,
  parameter int NUM_IRQ       = 4,
  parameter int IRQ_CODE_BASE = 16,
  parameter int DRAIN_CYCLES  = 3,
  parameter int DEBUG_EBREAK  = 1,
  parameter int MRET_PLUS4    = 1
) (
  input logic clk,
  input logic reset,
  trap_sequencer_if.master bus
);
  import trap_sequencer_pkg::*;
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  logic [3:0]      state;
  trap_kind_e      kind_q;
  logic [XLEN-1:0] pc_q, cause_q, tval_q, tgt_q, mst_q, mst_trap, mst_mret, base;
  logic [3:0]      cnt_q;
  logic            mie_q, irq_valid, idle, dbg_q;
  logic [IW-1:0]   irq_idx;
  irq_priority_encoder #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_enc (
    .req(bus.irq_pending & bus.irq_enable), .valid(irq_valid), .idx(irq_idx)
  );
  assign idle = state == S_IDLE;
  assign base = {bus.csr_rdata[XLEN-1:2], 2'b00};
  always_comb begin
    mst_trap = mst_q;
    mst_trap[MPIE_BIT] = mst_q[MIE_BIT];
    mst_trap[MIE_BIT] = 1'b0;
    mst_trap[MPP_LO+:2] = 2'b11;
    mst_mret = mst_q;
    mst_mret[MIE_BIT] = mst_q[MPIE_BIT];
    mst_mret[MPIE_BIT] = 1'b1;
  end
  // idle cycles keep mstatus on the port so the MIE copy stays fresh
  assign bus.csr_addr = reset ? 12'h000 :
                        (state == S_W_MEPC || state == S_R_MEPC) ? CSR_MEPC :
                        state == S_W_MCAUSE ? CSR_MCAUSE :
                        state == S_W_MTVAL  ? CSR_MTVAL :
                        state == S_R_MTVEC  ? CSR_MTVEC : CSR_MSTATUS;
  assign bus.csr_we = state inside {S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTATUS, S_W_MSTATUS_M};
  assign bus.csr_wdata = state == S_W_MEPC      ? pc_q :
                         state == S_W_MCAUSE    ? cause_q :
                         state == S_W_MTVAL     ? tval_q :
                         state == S_W_MSTATUS   ? mst_trap :
                         state == S_W_MSTATUS_M ? mst_mret : '0;
  assign bus.busy = !idle && state != S_REDIRECT;
  assign bus.redirect_valid = state == S_REDIRECT;
  assign bus.flush = state == S_REDIRECT;
  assign bus.redirect_pc = bus.redirect_valid ? tgt_q : '0;
  assign bus.ic_clean = !reset && idle && bus.trap_valid && bus.trap_kind == K_FENCEI;
  assign bus.debug_mode = dbg_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      kind_q <= K_EXC;
      pc_q <= '0;
      cause_q <= '0;
      tval_q <= '0;
      tgt_q <= '0;
      mst_q <= '0;
      cnt_q <= '0;
      mie_q <= 1'b0;
      dbg_q <= 1'b0;
    end else begin
      if (bus.csr_addr == CSR_MSTATUS) mie_q <= bus.csr_we ? bus.csr_wdata[MIE_BIT] : bus.csr_rdata[MIE_BIT];
      case (state)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.trap_valid) begin
            kind_q <= bus.trap_kind;
            pc_q <= bus.trap_pc;
            tval_q <= bus.trap_tval;
            case (bus.trap_kind)
              K_EXC: begin
                cause_q <= XLEN'(bus.trap_code);
                state <= S_W_MEPC;
              end
              K_EBREAK: begin
                cause_q <= XLEN'(CAUSE_BREAKPOINT);
                state <= S_W_MEPC;
              end
              K_ECALL: begin
                cause_q <= XLEN'(CAUSE_ECALL_M);
                state <= DRAIN_CYCLES == 0 ? S_W_MEPC : S_DRAIN;
              end
              K_MRET: begin
                dbg_q <= 1'b0;
                state <= S_R_MEPC;
              end
              default: ;
            endcase
          end else if (mie_q && irq_valid) begin
            kind_q <= K_EXC;
            cause_q <= {1'b1, (XLEN-1)'(IRQ_CODE_BASE) + (XLEN-1)'(irq_idx)};
            pc_q <= bus.irq_pc;
            tval_q <= '0;
            state <= DRAIN_CYCLES == 0 ? S_W_MEPC : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == 4'(DRAIN_CYCLES - 1)) state <= S_W_MEPC;
          else cnt_q <= cnt_q + 4'd1;
        end
        S_W_MEPC: state <= S_W_MCAUSE;
        S_W_MCAUSE: begin
          if (DEBUG_EBREAK != 0 && kind_q == K_EBREAK) begin
            dbg_q <= 1'b1;
            state <= S_IDLE;
          end else state <= S_W_MTVAL;
        end
        S_W_MTVAL: state <= S_R_MSTATUS;
        S_R_MSTATUS: begin
          mst_q <= bus.csr_rdata;
          state <= S_W_MSTATUS;
        end
        S_W_MSTATUS: state <= S_R_MTVEC;
        S_R_MTVEC: begin
          tgt_q <= (bus.csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1]) ? base + XLEN'({cause_q[4:0], 2'b00}) : base;
          state <= S_REDIRECT;
        end
        S_R_MEPC: begin
          tgt_q <= base + XLEN'(MRET_PLUS4 != 0 ? 3'd4 : 3'd0);
          state <= S_R_MSTATUS_M;
        end
        S_R_MSTATUS_M: begin
          mst_q <= bus.csr_rdata;
          state <= S_W_MSTATUS_M;
        end
        S_W_MSTATUS_M: state <= S_REDIRECT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
